// File: rtl/draw_pkg.sv
// Constants shared by the draw unit, memory controller and pixel-RAM write buffer.
package draw_pkg;

  localparam int PRAM_DATA_W   = 16;
  localparam int PRAM_BUF_LOG2 = 4;
  localparam int PRAM_AF_SLOTS = 2;

  // One extra wrap bit distinguishes full from empty when the low bits match.
  function automatic int pram_ptr_w(input int addr_log2);
    return addr_log2 + 1;
  endfunction

  typedef logic [pram_ptr_w(PRAM_BUF_LOG2)-1:0] pram_level_t;

endpackage

// File: rtl/pram_buf_mem.sv
// Dual-port register array: one synchronous write port and one asynchronous read port.
module pram_buf_mem #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // NOTE: storage has no reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/pram_write_buffer.sv
// FWFT write buffer between the CPU pixel-RAM write path and the draw unit.
// Optional macro PRAM_BUF_DROP_CNT_EN adds a saturating 8-bit drop_count output.
module pram_write_buffer
  import draw_pkg::*;
#(
  parameter int DATA_W    = PRAM_DATA_W,
  parameter int ADDR_LOG2 = PRAM_BUF_LOG2,
  parameter int AF_SLOTS  = PRAM_AF_SLOTS
) (
  input  logic                 CLK_50MHZ,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 wr_en,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic                 rd_ready,
  output logic                 rd_valid,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 full,
  output logic                 almost_full,
  output logic                 empty,
  output logic [ADDR_LOG2:0]   level,
  output logic                 overflow
`ifdef PRAM_BUF_DROP_CNT_EN
  ,
  output logic [7:0]           drop_count
`endif
);

  localparam int PTR_W = pram_ptr_w(ADDR_LOG2);
  localparam int DEPTH = 1 << ADDR_LOG2;

  typedef logic [PTR_W-1:0] ptr_t;

  ptr_t              wr_ptr_q, wr_ptr_d;
  ptr_t              rd_ptr_q, rd_ptr_d;
  logic              overflow_q, overflow_d;
  logic              pop, push, drop;
  logic [DATA_W-1:0] mem_rd_data;

  assign empty       = (wr_ptr_q == rd_ptr_q);
  assign full        = (wr_ptr_q[ADDR_LOG2] != rd_ptr_q[ADDR_LOG2]) &&
                       (wr_ptr_q[ADDR_LOG2-1:0] == rd_ptr_q[ADDR_LOG2-1:0]);
  assign level       = wr_ptr_q - rd_ptr_q;
  assign almost_full = (DEPTH - int'(level)) <= AF_SLOTS;
  assign rd_valid    = !empty;
  assign rd_data     = rd_valid ? mem_rd_data : '0;
  assign overflow    = overflow_q;

  // A full buffer still takes a word when the head leaves in the same cycle.
  assign pop  = rd_valid && rd_ready;
  assign push = wr_en && (!full || pop);
  assign drop = wr_en && full && !pop;

  always_comb begin
    // NOTE: defaults first so no path leaves a _d signal unassigned (no latches).
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
      if (drop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge CLK_50MHZ or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef PRAM_BUF_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (flush)                            drop_cnt_d = '0;
    else if (drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge CLK_50MHZ or negedge reset) begin
    if (!reset) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`endif

  pram_buf_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_LOG2)
  ) u_mem (
    .clk     (CLK_50MHZ),
    .wr_en   (push && !flush),
    .wr_addr (wr_ptr_q[ADDR_LOG2-1:0]),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_q[ADDR_LOG2-1:0]),
    .rd_data (mem_rd_data)
  );

endmodule

// File: tb/tb_pram_write_buffer.sv
// Randomised and directed bench for pram_write_buffer against a queue-based reference model.
module tb_pram_write_buffer;
  import draw_pkg::*;

  localparam int DW    = PRAM_DATA_W;
  localparam int DEPTH = 1 << PRAM_BUF_LOG2;
  localparam int AF    = PRAM_AF_SLOTS;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              wr_en;
  logic [DW-1:0]     wr_data;
  logic              rd_ready;
  logic              rd_valid;
  logic [DW-1:0]     rd_data;
  logic              full;
  logic              almost_full;
  logic              empty;
  pram_level_t       level;
  logic              overflow;
`ifdef PRAM_BUF_DROP_CNT_EN
  logic [7:0]        drop_count;
`endif

  always #10 clk = ~clk;

  pram_write_buffer dut (
    .CLK_50MHZ   (clk),
    .reset       (reset),
    .flush       (flush),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .rd_ready    (rd_ready),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .full        (full),
    .almost_full (almost_full),
    .empty       (empty),
    .level       (level),
    .overflow    (overflow)
`ifdef PRAM_BUF_DROP_CNT_EN
    ,
    .drop_count  (drop_count)
`endif
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [DW-1:0] model_q [$];
  bit            model_ovf;
  int            model_drops;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    model_q.delete();
    model_ovf   = 1'b0;
    model_drops = 0;
  endtask

  task automatic check_outputs(input string tag);
    int n;
    n = model_q.size();
    check({tag, ".level"},       32'(level),       32'(n));
    check({tag, ".empty"},       32'(empty),       32'(n == 0));
    check({tag, ".rd_valid"},    32'(rd_valid),    32'(n != 0));
    check({tag, ".full"},        32'(full),        32'(n == DEPTH));
    check({tag, ".almost_full"}, 32'(almost_full), 32'((DEPTH - n) <= AF));
    check({tag, ".overflow"},    32'(overflow),    32'(model_ovf));
    check({tag, ".rd_data"},     32'(rd_data),     (n != 0) ? 32'(model_q[0]) : 32'h0);
`ifdef PRAM_BUF_DROP_CNT_EN
    check({tag, ".drop_count"},  32'(drop_count),  32'(model_drops));
`endif
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then advance the model.
  task automatic step(input string tag, input bit wr, input logic [DW-1:0] d,
                      input bit rdy, input bit fl);
    logic [DW-1:0] head;
    wr_en = wr; wr_data = d; rd_ready = rdy; flush = fl;
    @(negedge clk);
    check_outputs(tag);
    if (fl) begin
      model_clear();
    end else begin
      if (rdy && model_q.size() != 0) head = model_q.pop_front();
      if (wr) begin
        if (model_q.size() < DEPTH) model_q.push_back(d);
        else begin
          model_ovf = 1'b1;
          if (model_drops < 255) model_drops++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < DEPTH + 1; i++) step(tag, 1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic async_reset(input string tag);
    wr_en = 1'b0; rd_ready = 1'b0; flush = 1'b0;
    reset = 1'b0;
    #3;
    model_clear();
    check_outputs(tag);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; wr_en = 1'b0; wr_data = '0; rd_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    idle("idle", 2);

    // Three pushes while stalled, then three pops in order.
    step("push3", 1'b1, 16'h1111, 1'b0, 1'b0);
    step("push3", 1'b1, 16'h2222, 1'b0, 1'b0);
    step("push3", 1'b1, 16'h3333, 1'b0, 1'b0);
    idle("hold", 2);
    for (int i = 0; i < 3; i++) step("pop3", 1'b0, '0, 1'b1, 1'b0);
    idle("pop3_done", 1);

    // Fill to full, drop one, then drain in order.
    for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, DW'(i), 1'b0, 1'b0);
    step("drop", 1'b1, 16'hBEEF, 1'b0, 1'b0);
    idle("after_drop", 1);
    drain("drain16");

    // Push and pop together while full: level holds, overflow stays clear.
    step("clr", 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) step("fill2", 1'b1, DW'(16'h0100 + i), 1'b0, 1'b0);
    step("full_pp", 1'b1, 16'hAAAA, 1'b1, 1'b0);
    idle("full_pp_hold", 1);
    drain("drain_aaaa");

    // Forty simultaneous push/pop cycles from level 1 wrap the pointers.
    step("seed", 1'b1, 16'h5000, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step("stream", 1'b1, DW'(16'h5001 + i), 1'b1, 1'b0);
    drain("drain_stream");

    // Level 7 with overflow set, then flush with a concurrent write.
    for (int i = 0; i < DEPTH; i++) step("fill3", 1'b1, DW'(16'h0700 + i), 1'b0, 1'b0);
    step("drop2", 1'b1, 16'hDEAD, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH - 7; i++) step("to7", 1'b0, '0, 1'b1, 1'b0);
    step("flush", 1'b1, 16'hCAFE, 1'b1, 1'b1);
    idle("post_flush", 1);

`ifdef PRAM_BUF_DROP_CNT_EN
    for (int i = 0; i < DEPTH; i++) step("fill4", 1'b1, DW'(i), 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) step("sat", 1'b1, DW'(i), 1'b0, 1'b0);
    step("sat_flush", 1'b0, '0, 1'b0, 1'b1);
    idle("sat_cleared", 1);
`endif

    // Randomised traffic with rare flushes.
    for (int i = 0; i < 600; i++)
      step("rand", ($urandom_range(99) < 60), DW'($urandom), ($urandom_range(99) < 50),
           ($urandom_range(63) == 0));

    // Asynchronous reset with five words held.
    for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, DW'(16'h0900 + i), 1'b0, 1'b0);
    idle("lvl5", 1);
    async_reset("mid_reset");
    step("post_rst", 1'b1, 16'h4242, 1'b0, 1'b0);
    idle("post_rst_valid", 1);
    drain("post_rst_drain");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pram_write_buffer.md
Name: pram_write_buffer

Overview:
Parametrised write buffer between the CPU's memory-mapped pixel-RAM write path and the draw unit. It generalises the existing single-flag `full` handshake into a depth- and width-configurable FIFO with level reporting, an almost-full warning and sticky overflow detection. The CPU side pushes words with a write strobe. The draw-unit side pops them with a valid/ready handshake. All logic runs on one clock domain.

Parameters:
DATA_W, 16, width of each buffered word
ADDR_LOG2, 4, log2 of FIFO depth (depth = 2**ADDR_LOG2 = 16)
AF_SLOTS, 2, almost_full asserts when free slots <= AF_SLOTS

Ports:
CLK_50MHZ  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
flush  in  1  synchronous clear of contents and overflow flag
wr_en  in  1  push request from memory controller
wr_data  in  DATA_W  word to push
rd_ready  in  1  draw unit accepts the head word this cycle
rd_valid  out  1  head word present on rd_data
rd_data  out  DATA_W  head word, first-word-fall-through
full  out  1  level == depth
almost_full  out  1  (depth - level) <= AF_SLOTS
empty  out  1  level == 0
level  out  ADDR_LOG2+1  current occupancy, 0..depth
overflow  out  1  sticky: a write was dropped

Behaviour:
- Reset (reset=0, asynchronous): read and write pointers are 0, level is 0, rd_valid is 0, overflow is 0, empty is 1, full is 0, almost_full is 0. rd_data reads 0 while empty.
- Storage: 2**ADDR_LOG2 entries. Pointers are ADDR_LOG2+1 bits with wrap bit.
  - full when the low bits are equal and the wrap bits differ.
  - empty when the pointers are equal.
  - Pointers wrap modulo 2*depth.
- Pop: occurs when rd_valid && rd_ready. The read pointer advances at the clock edge. The next head word appears on rd_data in the same cycle the pointer changes; there are no bubbles on back-to-back pops.
- Push:
  - Accepted when wr_en && (!full || pop). A push while full is accepted only if a pop occurs in the same cycle; level is then unchanged.
  - wr_en && full && !pop drops the word, leaves contents unchanged, and sets overflow on the next edge.
- Latency: a word written into an empty buffer raises rd_valid on the following cycle. There is no combinational bypass from wr_data to rd_data.
- Simultaneous push and pop with level >= 1: both pointers advance, level holds.
- level updates:
  - +1 for push only
  - -1 for pop only
  - 0 for both or neither
  - No wrap below 0 or above depth; an illegal pop is impossible because pop requires rd_valid.
- rd_valid equals !empty, registered state (not derived from inputs).
- flush=1 (when reset=1):
  - Next edge: pointers and level go to 0, and overflow clears.
  - Any same-cycle push or pop is discarded; flush has priority.
- Reset asserted mid-operation: all state clears immediately and contents are discarded. When reset releases, the first push behaves as a push into an empty buffer.
- rd_data must stay stable while rd_valid=1 and rd_ready=0.

Optional Feature:
PRAM_BUF_DROP_CNT_EN
- Defined: adds output port drop_count (8 bits). It increments by 1 on every dropped push, saturates at 255, and clears on reset or flush. overflow behaves as before.
- Undefined: port and counter are absent; only the sticky overflow reports drops.

Decomposition:
- Shared package (draw_pkg): PRAM_DATA_W=16 and PRAM_BUF_LOG2=4 defaults, the pointer width derivation, and a typedef for the level/occupancy type. The draw unit and memory controller import the same constants.
- One sub-module: pram_buf_mem, a simple dual-port register array.
  - Write port: address, data, enable.
  - Asynchronous read port on the read pointer, which gives first-word-fall-through.
- Pointer, flag and level logic stays in pram_write_buffer.

Test Plan:
- Reset then idle -> empty=1, rd_valid=0, level=0, full=0, overflow=0. Assert reset low mid-run with level=5 -> level=0 immediately.
- Push 0x1111, 0x2222, 0x3333 on consecutive cycles with rd_ready=0 -> rd_valid rises one cycle after the first push, rd_data=0x1111 held, level=3. Then rd_ready=1 for 3 cycles -> 0x1111, 0x2222, 0x3333 popped in order, then empty=1.
- Push 16 words 0x0000..0x000F -> almost_full at level 14, full at 16. A 17th push of 0xBEEF -> dropped, overflow=1, contents unchanged. Drain -> 0x0000..0x000F in order.
- With full=1, push 0xAAAA and pop in the same cycle -> level stays 16, 0xAAAA is last out after draining, overflow stays 0.
- Continuous simultaneous push/pop for 40 cycles from level=1 -> level constant at 1, pointers wrap past 2*depth, data order preserved.
- flush asserted with level=7, overflow=1 and wr_en=1 -> next cycle level=0, empty=1, overflow=0, pushed word discarded. With PRAM_BUF_DROP_CNT_EN: 300 dropped pushes -> drop_count=255, and flush -> 0.
